rv32i_seq_ctrl: RTL and testbench

RV32I_SEQ_CTRL -- requirements
Module: rv32i_seq_ctrl

---
 rtl/rv32i_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_rv32i_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_seq_ctrl.sv
// Multi-cycle RV32I sequencer: fetch, decode, execute and write back
// a small integer subset, halting on illegal opcodes or misaligned targets.
module rv32i_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_q,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic [31:0] dec_imm,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        halted,
    output logic [1:0]  halt_cause
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] next_pc_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_addi;
    logic        is_add;
    logic        is_sub;
    logic        is_br;
    logic        is_jal;
    logic        legal;
    logic        writes;
    logic        taken;
    logic [31:0] result;
    logic [31:0] nx_pc;
    logic        misaligned;
    logic        unused_dec;

    // Register indices are resolved by the external decoder and file.
    assign unused_dec = ^{dec_rs1, dec_rs2, instr_q[24:15], instr_q[11:7]};

    assign opcode  = instr_q[6:0];
    assign funct3  = instr_q[14:12];
    assign funct7  = instr_q[31:25];

    assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000)
                     && (funct7 == 7'b0000000);
    assign is_sub  = (opcode == 7'b0110011) && (funct3 == 3'b000)
                     && (funct7 == 7'b0100000);
    assign is_br   = (opcode == 7'b1100011) && (funct3[2:1] != 2'b01);
    assign is_jal  = (opcode == 7'b1101111);

    always_comb begin
        legal  = 1'b0;
        writes = 1'b0;
        taken  = 1'b0;
        result = 32'h0;
        unique case (1'b1)
            is_addi: begin
                legal  = 1'b1;
                writes = 1'b1;
                result = rs1_data + dec_imm;
            end
            is_add: begin
                legal  = 1'b1;
                writes = 1'b1;
                result = rs1_data + rs2_data;
            end
            is_sub: begin
                legal  = 1'b1;
                writes = 1'b1;
                result = rs1_data - rs2_data;
            end
            is_br: begin
                legal = 1'b1;
                case (funct3)
                    3'b000:  taken = (rs1_data == rs2_data);
                    3'b001:  taken = (rs1_data != rs2_data);
                    3'b100:  taken = ($signed(rs1_data) < $signed(rs2_data));
                    3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
                    3'b110:  taken = (rs1_data < rs2_data);
                    3'b111:  taken = (rs1_data >= rs2_data);
                    default: taken = 1'b0;
                endcase
            end
            is_jal: begin
                legal  = 1'b1;
                writes = 1'b1;
                taken  = 1'b1;
                result = pc + 32'd4;
            end
            default: legal = 1'b0;
        endcase
    end

    assign nx_pc      = taken ? (pc + dec_imm) : (pc + 32'd4);
    assign misaligned = nx_pc[1];

    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc;

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:   if (imem_ack) state_nx = DECODE;
            DECODE:  state_nx = EXEC;
            EXEC:    state_nx = (!legal || misaligned) ? HALT : WB;
            WB:      state_nx = FETCH;
            HALT:    state_nx = HALT;
            default: state_nx = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            instret    <= 32'h0;
            instr_q    <= 32'h0;
            halted     <= 1'b0;
            halt_cause <= 2'b00;
            rf_we      <= 1'b0;
            rf_waddr   <= 5'h0;
            rf_wdata   <= 32'h0;
            next_pc_q  <= 32'h0;
        end else begin
            state <= state_nx;
            case (state)
                FETCH: begin
                    if (imem_ack) instr_q <= imem_rdata;
                end
                EXEC: begin
                    if (!legal) begin
                        halted     <= 1'b1;
                        halt_cause <= 2'b01;
                    end else if (misaligned) begin
                        halted     <= 1'b1;
                        halt_cause <= 2'b10;
                    end else begin
                        rf_we     <= writes && (dec_rd != 5'd0);
                        rf_waddr  <= dec_rd;
                        rf_wdata  <= result;
                        next_pc_q <= nx_pc;
                    end
                end
                WB: begin
                    rf_we   <= 1'b0;
                    pc      <= next_pc_q;
                    instret <= instret + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_seq_ctrl.sv
// Directed bench for rv32i_seq_ctrl: reference ISA model feeds a
// scoreboard of expected write-back and next-PC results.
module tb_rv32i_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr_q;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [31:0] dec_imm, rs1_data, rs2_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pc, instret;
    logic        halted;
    logic [1:0]  halt_cause;

    always #5 clk = ~clk;

    rv32i_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_q(instr_q),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_imm(dec_imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc(pc), .instret(instret),
        .halted(halted), .halt_cause(halt_cause)
    );

    logic [31:0] regs [32];

    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction
    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction
    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // Environment decoder and register file around the sequencer.
    always_comb begin
        dec_rs1  = instr_q[19:15];
        dec_rs2  = instr_q[24:20];
        dec_rd   = instr_q[11:7];
        case (instr_q[6:0])
            7'b1100011: dec_imm = imm_b(instr_q);
            7'b1101111: dec_imm = imm_j(instr_q);
            default:    dec_imm = imm_i(instr_q);
        endcase
        rs1_data = regs[dec_rs1];
        rs2_data = regs[dec_rs2];
    end

    typedef struct {
        bit        halt;
        bit [1:0]  cause;
        bit        we;
        bit [4:0]  rd;
        bit [31:0] wd;
        bit [31:0] npc;
    } exp_t;

    exp_t        sb[$];
    int          ntests = 0;
    int          nfail  = 0;
    logic [31:0] pc_m   = 32'h0;
    logic [31:0] ret_m  = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t predict(input logic [31:0] i);
        exp_t        e;
        logic [31:0] a, b;
        bit          ill, tk;
        a   = regs[i[19:15]];
        b   = regs[i[24:20]];
        e   = '{halt: 0, cause: 0, we: 0, rd: i[11:7], wd: 0, npc: pc_m + 4};
        ill = 0;
        tk  = 0;
        case (i[6:0])
            7'b0010011: begin
                if (i[14:12] == 3'd0) begin
                    e.we = 1; e.wd = a + imm_i(i);
                end else ill = 1;
            end
            7'b0110011: begin
                if (i[14:12] == 3'd0 && i[31:25] == 7'h00) begin
                    e.we = 1; e.wd = a + b;
                end else if (i[14:12] == 3'd0 && i[31:25] == 7'h20) begin
                    e.we = 1; e.wd = a - b;
                end else ill = 1;
            end
            7'b1100011: begin
                case (i[14:12])
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = (int'(a) < int'(b));
                    3'd5: tk = (int'(a) >= int'(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: ill = 1;
                endcase
                if (tk) e.npc = pc_m + imm_b(i);
            end
            7'b1101111: begin
                e.we = 1; e.wd = pc_m + 4; e.npc = pc_m + imm_j(i);
            end
            default: ill = 1;
        endcase
        if (e.rd == 5'd0) e.we = 0;
        if (ill) begin
            e.halt = 1; e.cause = 2'b01; e.we = 0;
        end else if (e.npc[1]) begin
            e.halt = 1; e.cause = 2'b10; e.we = 0;
        end
        return e;
    endfunction

    task automatic run(input logic [31:0] i, input int dly, input bit stray);
        exp_t e;
        chk("req_fetch", {31'h0, imem_req}, 32'd1);
        chk("addr_fetch", imem_addr, pc_m);
        for (int k = 0; k < dly; k++) begin
            imem_ack = 1'b0;
            tick();
            chk("req_wait", {31'h0, imem_req}, 32'd1);
            chk("addr_wait", imem_addr, pc_m);
        end
        imem_ack   = 1'b1;
        imem_rdata = i;
        sb.push_back(predict(i));
        tick();
        imem_ack = 1'b0;
        chk("instr_q", instr_q, i);
        chk("we_decode", {31'h0, rf_we}, 32'd0);
        if (stray) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end
        tick();
        chk("we_exec", {31'h0, rf_we}, 32'd0);
        tick();
        imem_ack = 1'b0;
        e = sb.pop_front();
        if (e.halt) begin
            chk("halted", {31'h0, halted}, 32'd1);
            chk("cause", {30'h0, halt_cause}, {30'h0, e.cause});
            chk("req_halt", {31'h0, imem_req}, 32'd0);
            chk("pc_halt", pc, pc_m);
            imem_ack = 1'b1;
            tick();
            tick();
            imem_ack = 1'b0;
            chk("we_halt", {31'h0, rf_we}, 32'd0);
            chk("pc_hold", pc, pc_m);
            chk("ret_hold", instret, ret_m);
            chk("iq_hold", instr_q, i);
            chk("req_hold", {31'h0, imem_req}, 32'd0);
        end else begin
            chk("we_wb", {31'h0, rf_we}, {31'h0, e.we});
            if (e.we) begin
                chk("waddr", {27'h0, rf_waddr}, {27'h0, e.rd});
                chk("wdata", rf_wdata, e.wd);
                regs[e.rd] = e.wd;
            end
            tick();
            pc_m  = e.npc;
            ret_m = ret_m + 1;
            chk("pc_next", pc, pc_m);
            chk("instret", instret, ret_m);
            chk("we_after", {31'h0, rf_we}, 32'd0);
            chk("halted_no", {31'h0, halted}, 32'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_req", {31'h0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ret", instret, 32'h0);
        chk("rst_iq", instr_q, 32'h0);
        chk("rst_halt", {30'h0, halted, 1'b0} | {30'h0, halt_cause}, 32'h0);
        chk("rst_we", {31'h0, rf_we}, 32'd0);
        chk("rst_wa", {27'h0, rf_waddr}, 32'd0);
        chk("rst_wd", rf_wdata, 32'h0);
        rst = 1'b0;
        #1;
        chk("req_after_rst", {31'h0, imem_req}, 32'd1);
        pc_m  = 32'h0;
        ret_m = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'h0;
        tick();
        do_reset();
        run(32'h00500093, 0, 1);  // addi x1,x0,5
        run(32'h00700113, 3, 1);  // addi x2,x0,7
        run(32'h002081B3, 0, 0);  // add  x3,x1,x2
        run(32'h40208233, 1, 0);  // sub  x4,x1,x2
        run(32'h00210463, 0, 0);  // beq  x2,x2,+8
        run(32'hFFF00293, 0, 0);  // addi x5,x0,-1
        run(32'h00100313, 0, 0);  // addi x6,x0,1
        run(32'h0062C463, 0, 0);  // blt  x5,x6,+8
        run(32'h0062E463, 0, 0);  // bltu x5,x6,+8
        run(32'h0062D463, 0, 0);  // bge  x5,x6,+8
        run(32'h0062F463, 0, 0);  // bgeu x5,x6,+8
        run(32'h00629463, 2, 0);  // bne  x5,x6,+8
        run(32'h00100013, 0, 0);  // addi x0,x0,1
        run(32'h008000EF, 0, 0);  // jal  x1,+8
        // Reset while a fetch is still waiting, with a late ack.
        tick();
        tick();
        chk("req_pending", {31'h0, imem_req}, 32'd1);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("req_in_rst", {31'h0, imem_req}, 32'd0);
        do_reset();
        imem_ack = 1'b0;
        chk("late_ack_iq", instr_q, 32'h0);
        run(32'h00500093, 0, 0);  // addi x1,x0,5
        run(32'h00002083, 0, 0);  // lw: illegal here
        do_reset();
        run(32'h0020006F, 0, 0);  // jal x0,+2: misaligned
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
